// File: rtl/adc_serial_rx_if.sv
// Signal bundle between the ADC serial receive stage and its surroundings:
// pacing/enable/serial-data inputs, ADC pin outputs and the sample bus.
interface adc_serial_rx_if #(
  parameter int DATA_BITS = 12
);
  logic                 tick;
  logic                 en;
  logic                 sdata;
  logic                 adc_cs_n;
  logic                 adc_sclk;
  logic [DATA_BITS-1:0] dout;
  logic                 dout_valid;
  logic                 lead_err;

  modport master (
    output tick, en, sdata,
    input  adc_cs_n, adc_sclk, dout, dout_valid, lead_err
  );

  modport slave (
    input  tick, en, sdata,
    output adc_cs_n, adc_sclk, dout, dout_valid, lead_err
  );
endinterface

// File: rtl/adc_serial_rx.sv
// AD7476-class serial receiver: derives CS/SCLK from the divider pacing tick,
// shifts in one 16-bit frame per FRAME_TICKS ticks and strobes out the 12-bit sample.
module adc_serial_rx #(
  parameter int DATA_BITS   = 12,
  parameter int LEAD_BITS   = 4,
  parameter int FRAME_TICKS = 128
) (
  input  logic clk,
  input  logic rst_n,
  adc_serial_rx_if.slave bus
);

  localparam int FRAME_BITS = DATA_BITS + LEAD_BITS;
  localparam int K_BITS     = $clog2(FRAME_TICKS);
  localparam logic [K_BITS-1:0] K_DONE = K_BITS'(2 * FRAME_BITS + 1);
  localparam logic [K_BITS-1:0] K_LAST = K_BITS'(FRAME_TICKS - 1);

  typedef enum logic [1:0] {WAIT, SHIFT, QUIET} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [K_BITS-1:0]     r_k;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_csN;
  logic                  r_sclk;
  logic                  r_valid;
  logic                  r_leadErr;
  logic [DATA_BITS-1:0]  r_dout;
  logic                  w_start;
  logic                  w_sclkFall;
  logic                  w_sclkRise;
  logic                  w_done;

  // Odd k drops SCLK, even k raises it and samples; the ADC changes sdata on the falling edge.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_sclkFall  = 1'b0;
    w_sclkRise  = 1'b0;
    w_done      = 1'b0;
    if (bus.tick) begin
      unique case (r_state)
        WAIT: begin
          if (bus.en) begin
            w_start     = 1'b1;
            w_nextState = SHIFT;
          end else begin
            w_nextState = QUIET;
          end
        end
        SHIFT: begin
          if (r_k == K_DONE) begin
            w_done      = 1'b1;
            w_nextState = QUIET;
          end else if (r_k[0]) begin
            w_sclkFall = 1'b1;
          end else begin
            w_sclkRise = 1'b1;
          end
        end
        QUIET: begin
          if (r_k == K_LAST) w_nextState = WAIT;
        end
        default: w_nextState = WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT;
    else        r_state <= w_nextState;
  end

  // Frame index runs free so frame starts stay on a fixed grid even when frames are skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k       <= '0;
      r_shift   <= '0;
      r_csN     <= 1'b1;
      r_sclk    <= 1'b1;
      r_valid   <= 1'b0;
      r_leadErr <= 1'b0;
      r_dout    <= '0;
    end else begin
      r_valid <= w_done;
      if (bus.tick) r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
      if (w_start) begin
        r_csN   <= 1'b0;
        r_shift <= '0;
      end
      if (w_sclkFall) r_sclk <= 1'b0;
      if (w_sclkRise) begin
        r_sclk  <= 1'b1;
        r_shift <= {r_shift[FRAME_BITS-2:0], bus.sdata};
      end
      if (w_done) begin
        r_csN     <= 1'b1;
        r_sclk    <= 1'b1;
        r_dout    <= r_shift[DATA_BITS-1:0];
        r_leadErr <= |r_shift[FRAME_BITS-1:DATA_BITS];
      end
    end
  end

  assign bus.adc_cs_n   = r_csN;
  assign bus.adc_sclk   = r_sclk;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.lead_err   = r_leadErr;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Scoreboard bench for adc_serial_rx: an ADC model serves queued frames, a monitor
// checks every captured sample plus CS/SCLK framing against hand-computed values.
module tb_adc_serial_rx;

  localparam int FRAME_TICKS = 128;
  // Shortened pacing period keeps the run small; frame spacing scales with it.
  localparam int TICK_PERIOD = 7;
  localparam int FRAME_CLK   = FRAME_TICKS * TICK_PERIOD;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   tickRun = 1'b0;

  adc_serial_rx_if #(.DATA_BITS(12)) bus ();

  adc_serial_rx #(
    .DATA_BITS  (12),
    .LEAD_BITS  (4),
    .FRAME_TICKS(FRAME_TICKS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] adcQ[$];
  logic [12:0] expQ[$];

  int   tickIdx = 0;
  int   cycle = 0;
  logic prevCs = 1'b1;
  logic prevSclk = 1'b1;
  logic prevValid = 1'b0;
  int   csTicks = 0;
  int   sclkRises = 0;
  bit   spacingOn = 1'b0;
  bit   haveLast = 1'b0;
  int   lastValidCycle = 0;
  bit   skipWindow = 1'b0;
  int   skipCsFalls = 0;

  logic [15:0] curWord = '0;
  int          bitIdx = 15;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] word, input logic [11:0] expDout, input logic expLead);
    adcQ.push_back(word);
    expQ.push_back({expLead, expDout});
  endtask

  task automatic waitTick(input int target, input int budget);
    int n = 0;
    while (tickIdx < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("tick_wait_timeout", int'(tickIdx >= target), 1);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() > 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("drain_timeout", expQ.size(), 0);
  endtask

  // Pacing pulse, one clk wide every TICK_PERIOD clks
  initial begin
    int divCnt = 0;
    bus.tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tickRun) begin
        if (divCnt == TICK_PERIOD - 1) begin
          bus.tick = 1'b1;
          divCnt   = 0;
        end else begin
          bus.tick = 1'b0;
          divCnt++;
        end
      end else begin
        bus.tick = 1'b0;
        divCnt   = 0;
      end
    end
  end

  // ADC model: CS falling loads the next frame, each SCLK falling edge presents the next bit
  always @(negedge bus.adc_cs_n or negedge bus.adc_sclk) begin
    if (!bus.adc_cs_n) begin
      if (bus.adc_sclk) begin
        curWord = (adcQ.size() > 0) ? adcQ.pop_front() : 16'h0000;
        bitIdx  = 15;
      end else if (bitIdx >= 0) begin
        bus.sdata = curWord[bitIdx];
        bitIdx--;
      end
    end
  end

  // Monitor: framing checks and scoreboard comparison on every dout_valid
  always @(posedge clk) begin
    logic [12:0] exp;
    #1;
    cycle++;
    if (!rst_n) begin
      tickIdx   = 0;
      prevCs    = 1'b1;
      prevSclk  = 1'b1;
      prevValid = 1'b0;
      csTicks   = 0;
      sclkRises = 0;
    end else begin
      if (prevCs && !bus.adc_cs_n) begin
        checkOutput("cs_fall_k", tickIdx % FRAME_TICKS, 0);
        if (skipWindow) skipCsFalls++;
        csTicks   = 0;
        sclkRises = 0;
      end
      if (bus.tick && !bus.adc_cs_n) csTicks++;
      if (!bus.adc_cs_n && !prevSclk && bus.adc_sclk) sclkRises++;
      if (!prevCs && bus.adc_cs_n) begin
        checkOutput("cs_low_ticks", csTicks, 33);
        checkOutput("sclk_rises", sclkRises, 16);
        checkOutput("valid_at_cs_rise", int'(bus.dout_valid), 1);
        checkOutput("sclk_high_at_end", int'(bus.adc_sclk), 1);
      end
      if (bus.dout_valid) begin
        checkOutput("valid_width", int'(prevValid), 0);
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_valid: got dout 0x%0h, expected no strobe", bus.dout);
        end else begin
          exp = expQ.pop_front();
          checkOutput("dout", int'(bus.dout), int'(exp[11:0]));
          checkOutput("lead_err", int'(bus.lead_err), int'(exp[12]));
        end
        if (spacingOn && haveLast)
          checkOutput("valid_spacing", cycle - lastValidCycle, FRAME_CLK);
        lastValidCycle = cycle;
        haveLast       = 1'b1;
      end
      if (bus.tick) tickIdx++;
      prevCs    = bus.adc_cs_n;
      prevSclk  = bus.adc_sclk;
      prevValid = bus.dout_valid;
    end
  end

  initial begin
    bus.en = 1'b0;
    rst_n  = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_cs_n", int'(bus.adc_cs_n), 1);
    checkOutput("reset_sclk", int'(bus.adc_sclk), 1);
    checkOutput("reset_dout", int'(bus.dout), 0);
    checkOutput("reset_valid", int'(bus.dout_valid), 0);
    checkOutput("reset_lead_err", int'(bus.lead_err), 0);

    applyStimulus(16'h0A5C, 12'hA5C, 1'b0);
    applyStimulus(16'h8FFF, 12'hFFF, 1'b1);
    applyStimulus(16'h0123, 12'h123, 1'b0);
    bus.en  = 1'b1;
    tickRun = 1'b1;
    waitDrain(4 * FRAME_CLK);

    // Skip the frame at tick 384; the next one must land on tick 512
    bus.en     = 1'b0;
    skipWindow = 1'b1;
    waitTick(3 * FRAME_TICKS + 10, 2 * FRAME_CLK);
    bus.en = 1'b1;
    waitTick(3 * FRAME_TICKS + 40, 2 * FRAME_CLK);
    skipWindow = 1'b0;
    checkOutput("skip_no_cs", skipCsFalls, 0);
    checkOutput("skip_hold_dout", int'(bus.dout), 12'h123);
    checkOutput("skip_hold_lead", int'(bus.lead_err), 0);
    applyStimulus(16'h0777, 12'h777, 1'b0);
    waitDrain(3 * FRAME_CLK);

    // Reset in the middle of shifting the frame at tick 640
    adcQ.push_back(16'h0333);
    waitTick(5 * FRAME_TICKS + 21, 3 * FRAME_CLK);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_cs_n", int'(bus.adc_cs_n), 1);
    checkOutput("async_rst_sclk", int'(bus.adc_sclk), 1);
    checkOutput("async_rst_valid", int'(bus.dout_valid), 0);
    checkOutput("async_rst_dout", int'(bus.dout), 0);
    repeat (5) @(negedge clk);

    applyStimulus(16'h05A5, 12'h5A5, 1'b0);
    applyStimulus(16'h0001, 12'h001, 1'b0);
    applyStimulus(16'h0800, 12'h800, 1'b0);
    applyStimulus(16'h0FFF, 12'hFFF, 1'b0);
    applyStimulus(16'h0000, 12'h000, 1'b0);
    applyStimulus(16'h0ABC, 12'hABC, 1'b0);
    applyStimulus(16'h4555, 12'h555, 1'b1);
    applyStimulus(16'h0FED, 12'hFED, 1'b0);
    applyStimulus(16'h1000, 12'h000, 1'b1);
    applyStimulus(16'h0AAA, 12'hAAA, 1'b0);
    applyStimulus(16'h0F0F, 12'hF0F, 1'b0);
    spacingOn = 1'b1;
    haveLast  = 1'b0;
    rst_n     = 1'b1;
    waitDrain(13 * FRAME_CLK);
    checkOutput("adc_queue_empty", adcQ.size(), 0);

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
